// File: rtl/mul_share_pkg.sv
// Shared constants, tag record and saturation helper for the shared 8x14 multiplier.
package mul_share_pkg;

  localparam int A_W      = 8;
  localparam int B_W      = 14;
  localparam int P_W      = 14;
  localparam int FULL_W   = 22;
  localparam int LAT      = 2;
  localparam int P_MAX    = 8191;
  localparam int P_MIN    = -8192;
  localparam int TAG_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic logic [P_W-1:0] sat_p(input logic signed [FULL_W-1:0] full);
    logic signed [FULL_W-1:0] hi;
    logic signed [FULL_W-1:0] lo;
    hi = FULL_W'(P_MAX);
    lo = FULL_W'(P_MIN);
    if (full > hi) begin
      return P_W'(P_MAX);
    end else if (full < lo) begin
      return P_W'(P_MIN);
    end else begin
      return full[P_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mul_share_dsp_core.sv
// Two-register 8x14 multiplier (operand regs, product reg) with a common clock enable.
// MUL_SHARE_SAT_EN selects a saturated 14-bit output instead of low-bit truncation.
module mul_share_dsp_core
  import mul_share_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [A_W-1:0]    a,
  input  logic [B_W-1:0]    b,
  output logic [FULL_W-1:0] full_p,
  output logic [P_W-1:0]    p
);

  logic        [A_W-1:0]    a_reg;
  logic signed [B_W-1:0]    b_reg;
  logic signed [FULL_W-1:0] prod_next;
  logic signed [FULL_W-1:0] full_reg;
  logic        [P_W-1:0]    p_next;
  logic        [P_W-1:0]    p_reg;

  // The 8-bit operand is unsigned, so it is zero-extended before the signed multiply.
  assign prod_next = FULL_W'($signed({1'b0, a_reg})) * FULL_W'(b_reg);

`ifdef MUL_SHARE_SAT_EN
  assign p_next = sat_p(prod_next);
`else
  assign p_next = prod_next[P_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      full_reg <= '0;
      p_reg    <= '0;
    end else if (ce) begin
      a_reg    <= a;
      b_reg    <= b;
      full_reg <= prod_next;
      p_reg    <= p_next;
    end
  end

  assign full_p = full_reg;
  assign p      = p_reg;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters, with an ID tag
// pipeline and whole-pipe stall on result backpressure. Optional macro: MUL_SHARE_SAT_EN.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*A_W-1:0]   req_a,
  input  logic [NUM_REQ*B_W-1:0]   req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [P_W-1:0]           res_p,
  output logic [$clog2(LAT+1)-1:0] inflight
);

  logic [A_W-1:0]      a_slot [NUM_REQ];
  logic [B_W-1:0]      b_slot [NUM_REQ];
  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic [ID_W-1:0]     grant_id;
  logic [A_W-1:0]      a_sel;
  logic [B_W-1:0]      b_sel;
  logic                ce;
  logic [ID_W-1:0]     last_grant_reg;
  tag_t                tag1_reg;
  tag_t                tag1_next;
  tag_t                tag2_reg;
  logic [TAG_ID_W-1:0] tag2_id_unused;
  logic [FULL_W-1:0]   prod_full_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign a_slot[gi] = req_a[gi*A_W +: A_W];
      assign b_slot[gi] = req_b[gi*B_W +: B_W];
    end
  endgenerate

  // A result waiting on a stalled consumer freezes every stage, including the core.
  assign ce = !(tag2_reg.valid && !res_ready);

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (i == (int'(last_grant_reg) + k) % NUM_REQ)) begin
          grant_any = 1'b1;
          grant[i]  = 1'b1;
          grant_id  = ID_W'(i);
          a_sel     = a_slot[i];
          b_sel     = b_slot[i];
        end
      end
    end
  end

  assign req_ready = grant & {NUM_REQ{ce}};

  always_comb begin
    tag1_next       = '0;
    tag1_next.valid = grant_any;
    tag1_next.id    = TAG_ID_W'(grant_id);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag1_reg       <= '0;
      tag2_reg       <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
    end else if (ce) begin
      tag1_reg <= tag1_next;
      tag2_reg <= tag1_reg;
      // With ce high any grant is an accepted handshake.
      if (grant_any) begin
        last_grant_reg <= grant_id;
      end
    end
  end

  mul_share_dsp_core u_core (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .a      (a_sel),
    .b      (b_sel),
    .full_p (prod_full_unused),
    .p      (res_p)
  );

  assign tag2_id_unused = tag2_reg.id;
  assign res_valid      = tag2_reg.valid;
  assign res_id         = tag2_id_unused[ID_W-1:0];
  assign inflight       = ($clog2(LAT+1))'(tag1_reg.valid) + ($clog2(LAT+1))'(tag2_reg.valid);

endmodule
